// File: rtl/kbd_scanbuf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | kbd_scanbuf: PS/2 scan-code decoder with modifier tracking and key FIFO  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module kbd_scanbuf #(
  parameter int ADDR_W = 4
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [7:0]        PS2_DATA,
  input  logic              PS2_HIT,
  input  logic              RD,
  input  logic              CLR_OVF,
  output logic [7:0]        O_DATA,
  output logic              READY,
  output logic [ADDR_W:0]   COUNT,
  output logic              SHIFT,
  output logic              CTRL,
  output logic              OVERFLOW
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EXT     = 3'd1;
  localparam logic [2:0] ST_BRK     = 3'd2;
  localparam logic [2:0] ST_EXT_BRK = 3'd3;
  localparam logic [2:0] ST_PAUSE   = 3'd4;

  localparam logic [7:0] B_EXT   = 8'hE0;
  localparam logic [7:0] B_BRK   = 8'hF0;
  localparam logic [7:0] B_PAUSE = 8'hE1;
  localparam logic [7:0] B_LSHF  = 8'h12;
  localparam logic [7:0] B_RSHF  = 8'h59;
  localparam logic [7:0] B_CTRL  = 8'h14;

  logic [2:0]        state_q,  state_d;
  logic [2:0]        pcnt_q,   pcnt_d;
  logic              lshift_q, lshift_d;
  logic              rshift_q, rshift_d;
  logic              lctrl_q,  lctrl_d;
  logic              rctrl_q,  rctrl_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              ovf_q,    ovf_d;
  logic [7:0]        mem_q [DEPTH];

  logic              push;
  logic [7:0]        push_data;
  logic              do_rd;
  logic              do_wr;
  logic              full;

  // Decoder: only bytes strobed by PS2_HIT move the state machine.
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    lshift_d  = lshift_q;
    rshift_d  = rshift_q;
    lctrl_d   = lctrl_q;
    rctrl_d   = rctrl_q;
    push      = 1'b0;
    push_data = 8'h00;
    if (PS2_HIT) begin
      case (state_q)
        ST_IDLE: begin
          if (PS2_DATA == B_EXT) begin
            state_d = ST_EXT;
          end else if (PS2_DATA == B_BRK) begin
            state_d = ST_BRK;
          end else if (PS2_DATA == B_PAUSE) begin
            state_d = ST_PAUSE;
            pcnt_d  = 3'd7;
          end else begin
            push      = 1'b1;
            push_data = {1'b0, PS2_DATA[6:0]};
            if (PS2_DATA == B_LSHF) lshift_d = 1'b1;
            if (PS2_DATA == B_RSHF) rshift_d = 1'b1;
            if (PS2_DATA == B_CTRL) lctrl_d  = 1'b1;
          end
        end
        ST_EXT: begin
          if (PS2_DATA == B_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (PS2_DATA != B_EXT) begin
            push      = 1'b1;
            push_data = {1'b1, PS2_DATA[6:0]};
            if (PS2_DATA == B_CTRL) rctrl_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (PS2_DATA == B_LSHF) lshift_d = 1'b0;
          if (PS2_DATA == B_RSHF) rshift_d = 1'b0;
          if (PS2_DATA == B_CTRL) lctrl_d  = 1'b0;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          if (PS2_DATA == B_CTRL) rctrl_d = 1'b0;
          state_d = ST_IDLE;
        end
        ST_PAUSE: begin
          // The pause sequence collapses into a single 0xE1 entry on its last byte.
          pcnt_d = pcnt_q - 3'd1;
          if (pcnt_q == 3'd1) begin
            push      = 1'b1;
            push_data = B_PAUSE;
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A read frees a slot in the same cycle, so a full FIFO can still accept a push.
  always_comb begin
    full     = (count_q == FULL_CNT);
    do_rd    = RD && (count_q != '0);
    do_wr    = push && (!full || do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_rd) count_d = count_q + 1'b1;
    if (!do_wr && do_rd) count_d = count_q - 1'b1;
    ovf_d = ovf_q;
    if (CLR_OVF) ovf_d = 1'b0;
    if (push && full && !do_rd) ovf_d = 1'b1;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      pcnt_q   <= 3'd0;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      lctrl_q  <= 1'b0;
      rctrl_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
      lctrl_q  <= lctrl_d;
      rctrl_q  <= rctrl_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET && do_wr) mem_q[wr_ptr_q] <= push_data;
  end

  assign READY    = (count_q != '0);
  assign O_DATA   = READY ? mem_q[rd_ptr_q] : 8'h00;
  assign COUNT    = count_q;
  assign SHIFT    = lshift_q | rshift_q;
  assign CTRL     = lctrl_q | rctrl_q;
  assign OVERFLOW = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_kbd_scanbuf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_kbd_scanbuf: scoreboard bench for kbd_scanbuf                         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_kbd_scanbuf;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ps2_data;
  logic       ps2_hit;
  logic       rd;
  logic       clr_ovf;
  logic [7:0] o_data;
  logic       ready;
  logic [4:0] count;
  logic       shift;
  logic       ctrl;
  logic       overflow;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];

  kbd_scanbuf #(.ADDR_W(4)) dut (
    .CLOCK    (clk),
    .RESET    (rst),
    .PS2_DATA (ps2_data),
    .PS2_HIT  (ps2_hit),
    .RD       (rd),
    .CLR_OVF  (clr_ovf),
    .O_DATA   (o_data),
    .READY    (ready),
    .COUNT    (count),
    .SHIFT    (shift),
    .CTRL     (ctrl),
    .OVERFLOW (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: every cycle the CPU pops a presented entry, compare against the scoreboard.
  always @(negedge clk) begin
    if (!rst && rd && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %02h, required no entry", o_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (o_data !== e) begin
          errors++;
          $display("FAIL pop_data: got %02h, required %02h", o_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h, required %02h", name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] b);
    ps2_data = b;
    ps2_hit  = 1'b1;
    @(posedge clk); #1;
    ps2_hit  = 1'b0;
  endtask

  task automatic send_make(input logic [7:0] b, input logic [7:0] e);
    exp_q.push_back(e);
    send(b);
  endtask

  task automatic pop(input int n);
    for (int i = 0; i < n; i++) begin
      rd = 1'b1;
      @(posedge clk); #1;
      rd = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    ps2_data = 8'h00;
    ps2_hit  = 1'b0;
    rd       = 1'b0;
    clr_ovf  = 1'b0;
    rst      = 1'b1;
    #1;
    do_reset();
    chk("reset_count", {3'b0, count}, 8'h00);
    chk("reset_flags", {3'b0, ready, shift, ctrl, overflow, 1'b0}, 8'h00);
    chk("reset_odata", o_data, 8'h00);

    // 1: make / break
    send_make(8'h1C, 8'h1C);
    send(8'hF0);
    send(8'h1C);
    chk("t1_count", {3'b0, count}, 8'h01);
    chk("t1_odata", o_data, 8'h1C);
    chk("t1_ready", {7'b0, ready}, 8'h01);
    pop(1);
    chk("t1_ready_after", {7'b0, ready}, 8'h00);
    chk("t1_count_after", {3'b0, count}, 8'h00);

    // 2: extended make with repeated E0, then shift tracking
    send(8'hE0);
    send_make(8'h75, 8'hF5);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("t2_count", {3'b0, count}, 8'h01);
    chk("t2_odata", o_data, 8'hF5);
    send_make(8'h12, 8'h12);
    send_make(8'h59, 8'h59);
    send(8'hF0);
    send(8'h12);
    chk("t2_shift_held", {7'b0, shift}, 8'h01);
    send(8'hF0);
    send(8'h59);
    chk("t2_shift_released", {7'b0, shift}, 8'h00);
    chk("t2_count3", {3'b0, count}, 8'h03);
    pop(3);

    // ctrl make/release
    send_make(8'h14, 8'h14);
    chk("ctrl_set", {7'b0, ctrl}, 8'h01);
    send(8'hF0);
    send(8'h14);
    chk("ctrl_clr", {7'b0, ctrl}, 8'h00);
    pop(1);

    // 3: pause sequence
    send(8'hE1);
    send(8'h14);
    chk("t3_ctrl_mid", {7'b0, ctrl}, 8'h00);
    send(8'h77);
    send(8'hE1);
    send(8'hF0);
    send(8'h14);
    send(8'hF0);
    chk("t3_count_before_last", {3'b0, count}, 8'h00);
    send_make(8'h77, 8'hE1);
    chk("t3_count", {3'b0, count}, 8'h01);
    chk("t3_odata", o_data, 8'hE1);
    chk("t3_ctrl", {7'b0, ctrl}, 8'h00);
    pop(1);

    // 4: overflow
    for (int i = 1; i <= 16; i++) send_make(8'(i), 8'(i));
    chk("t4_ovf_before", {7'b0, overflow}, 8'h00);
    send(8'h11);
    chk("t4_count", {3'b0, count}, 8'h10);
    chk("t4_ovf", {7'b0, overflow}, 8'h01);
    chk("t4_odata", o_data, 8'h01);
    pop(16);
    chk("t4_empty", {3'b0, count}, 8'h00);
    chk("t4_ovf_sticky", {7'b0, overflow}, 8'h01);
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    chk("t4_ovf_cleared", {7'b0, overflow}, 8'h00);

    // 5: push and pop together while full
    for (int i = 1; i <= 16; i++) send_make(8'(i), 8'(i));
    exp_q.push_back(8'h2A);
    ps2_data = 8'h2A;
    ps2_hit  = 1'b1;
    rd       = 1'b1;
    @(posedge clk); #1;
    ps2_hit  = 1'b0;
    rd       = 1'b0;
    chk("t5_count", {3'b0, count}, 8'h10);
    chk("t5_ovf", {7'b0, overflow}, 8'h00);
    pop(16);
    chk("t5_empty", {3'b0, count}, 8'h00);
    pop(1);
    chk("t5_rd_empty", {3'b0, count}, 8'h00);
    chk("t5_rd_empty_ready", {7'b0, ready}, 8'h00);

    // 6: reset mid-sequence
    send_make(8'h12, 8'h12);
    send(8'hF0);
    do_reset();
    chk("t6_shift_reset", {7'b0, shift}, 8'h00);
    send_make(8'h1C, 8'h1C);
    chk("t6_count", {3'b0, count}, 8'h01);
    chk("t6_odata", o_data, 8'h1C);
    chk("t6_flags", {5'b0, shift, ctrl, overflow}, 8'h00);
    pop(1);

    chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kbd_scanbuf.md
Name: kbd_scanbuf

Overview:
- Consumes the byte stream produced by the PS/2 keyboard receiver (received_data / received_data_en, 50 MHz domain).
- Decodes make/break/extended/pause prefixes and tracks modifier state.
- Queues one key-code byte per key press in a FIFO that the CPU reads through the memory controller as a memory-mapped port.
- Sits directly downstream of ps2keyboard and upstream of the CPU read mux.

Parameters:
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W entries (16).

Ports:
- CLOCK  in  1  system clock (clock_50, same domain as ps2keyboard)
- RESET  in  1  synchronous, active-high reset
- PS2_DATA  in  8  received scan-code byte; valid when PS2_HIT = 1
- PS2_HIT  in  1  one-cycle strobe, new byte present
- RD  in  1  pop strobe from the CPU side; one entry per asserted cycle
- CLR_OVF  in  1  clears the OVERFLOW flag
- O_DATA  out  8  FIFO head entry; valid when READY = 1
- READY  out  1  FIFO non-empty
- COUNT  out  ADDR_W+1  number of queued entries (0..2**ADDR_W)
- SHIFT  out  1  left (0x12) or right (0x59) shift held
- CTRL  out  1  ctrl (0x14, plain or E0-prefixed) held
- OVERFLOW  out  1  sticky; a key code was dropped because the FIFO was full

Behaviour:
- Reset:
  - All outputs are 0; decoder state is IDLE.
  - FIFO pointers and count are 0; the pause counter is 0.
  - Reset applied mid-sequence, for example after F0, discards the partial sequence.
- Decoder FSM; it advances only on cycles where PS2_HIT = 1:
  - IDLE:
    - 0xE0 -> EXT.
    - 0xF0 -> BRK.
    - 0xE1 -> PAUSE, load pause counter with 7.
    - Any other byte b is a make event: push b & 0x7F and update modifiers.
  - EXT:
    - 0xF0 -> EXT_BRK.
    - 0xE0 -> stay in EXT.
    - Other byte b is an extended make: push b | 0x80, update CTRL if b = 0x14, go to IDLE.
  - BRK: byte b is a release; update modifiers (clear); push nothing; go to IDLE.
  - EXT_BRK: byte b is an extended release; clear CTRL if b = 0x14; push nothing; go to IDLE.
  - PAUSE:
    - Decrement the counter on each byte.
    - On the byte that brings the counter to 0, push 0xE1 and go to IDLE.
    - All bytes of the sequence are otherwise discarded.
- Modifier bookkeeping:
  - SHIFT is set on make 0x12 or 0x59.
  - SHIFT is cleared only when both shift keys are released; keep separate left and right bits internally.
  - Modifier make codes are also pushed into the FIFO.
  - Typematic repeat (repeated make without a break) pushes a code each time.
- FIFO:
  - Write at posedge on a push event.
  - A push at edge n makes READY = 1 and O_DATA valid after edge n; the CPU can sample it at edge n+1.
  - O_DATA shows the head combinationally from the registered read pointer.
  - RD when empty is ignored: COUNT stays 0 and the pointers do not move.
  - Push when full and no RD: the byte is dropped, OVERFLOW is set to 1, and the FIFO contents are unchanged.
  - Push and RD in the same cycle when full: both occur, COUNT stays at 2**ADDR_W, no overflow.
  - Push and RD in the same cycle when non-empty and not full: both occur, COUNT unchanged.
  - Pointers wrap modulo 2**ADDR_W.
  - COUNT is a separate register, so full and empty are unambiguous.
- OVERFLOW:
  - Cleared by CLR_OVF.
  - If CLR_OVF and an overflowing push occur in the same cycle, set wins.
- PS2_HIT is assumed to be a single-cycle pulse; a held-high PS2_HIT is treated as repeated bytes.

Test Plan:
1. Reset, then bytes 0x1C, F0, 1C. Required: COUNT = 1, O_DATA = 0x1C, READY = 1. One RD: READY = 0, COUNT = 0.
2. Bytes E0 75 E0 F0 75. Required: exactly one entry, 0xF5, with the decoder back in IDLE. Then bytes 12, 59, F0 12. Required: SHIFT = 1; after F0 59, SHIFT = 0.
3. Pause sequence E1 14 77 E1 F0 14 F0 77. Required: exactly one entry, 0xE1, and CTRL stays 0.
4. Push 17 makes (0x01..0x11) with no RD. Required: COUNT = 16, OVERFLOW = 1, O_DATA = 0x01. Sixteen RDs must return 0x01..0x10 in order. Pulsing CLR_OVF clears OVERFLOW.
5. With the FIFO full, PS2_HIT (0x2A) and RD in the same cycle. Required: COUNT = 16, OVERFLOW = 0, and 0x2A is the last entry read. RD on an empty FIFO: COUNT remains 0.
6. Assert RESET after byte F0, then send 0x1C. Required: 0x1C is queued as a make (the BRK state was discarded); SHIFT = CTRL = OVERFLOW = 0.
